// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: bundle of the two requester ports, the shared read-data
// return and the combinational ROM hookup used by rom_arbiter.
// slave  = arbiter side, master = requesters plus ROM side.
interface rom_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              valid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              valid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_out;
    logic              busy;

    modport slave (
        input  req0, addr0, req1, addr1, rom_out,
        output valid0, valid1, rdata, rom_addr, busy
    );

    modport master (
        output req0, addr0, req1, addr1, rom_out,
        input  valid0, valid1, rdata, rom_addr, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port arbiter in front of a single combinational ROM.
// Each read goes IDLE -> ACCESS (ROM address registered) -> RESP (data and
// valid presented for one cycle). From RESP a pending request on the other
// port is granted directly, so alternating reads sustain one per 2 cycles.
// Optional feature: define ROM_ARB_ROUND_ROBIN_EN to break simultaneous
// requests in IDLE towards the port that was not granted last; without it
// port 0 always wins a tie.
module rom_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input logic             clk,
    input logic             reset,
    rom_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              valid0_q, valid0_d;
    logic              valid1_q, valid1_d;

    logic              tie_winner;
    logic              idle_winner;
    logic              other_req;

    // Tie-break choice used only when both ports request from IDLE.
`ifdef ROM_ARB_ROUND_ROBIN_EN
    assign tie_winner = ~last_owner_q;
`else
    assign tie_winner = 1'b0;
`endif

    // A lone request wins outright; a lone req1 selects port 1.
    assign idle_winner = (bus.req0 && bus.req1) ? tie_winner : bus.req1;
    // In RESP only the non-owner's request matters.
    assign other_req   = owner_q ? bus.req0 : bus.req1;

    // Next-state, grant and capture decisions.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rom_addr_d   = rom_addr_q;
        rdata_d      = rdata_q;
        valid0_d     = 1'b0;
        valid1_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d      = idle_winner;
                    last_owner_d = idle_winner;
                    rom_addr_d   = idle_winner ? bus.addr1 : bus.addr0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d  = bus.rom_out;
                valid0_d = ~owner_q;
                valid1_d = owner_q;
                state_d  = RESP;
            end
            RESP: begin
                if (other_req) begin
                    owner_d      = ~owner_q;
                    last_owner_d = ~owner_q;
                    rom_addr_d   = owner_q ? bus.addr0 : bus.addr1;
                    state_d      = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            rom_addr_q   <= '0;
            rdata_q      <= '0;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rom_addr_q   <= rom_addr_d;
            rdata_q      <= rdata_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
        end
    end

    assign bus.valid0   = valid0_q;
    assign bus.valid1   = valid1_q;
    assign bus.rdata    = rdata_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = (state_q != IDLE);
endmodule
